// File: rtl/pipa_pkg.sv
// Shared constants and types for the PIPA moding scheduler.
// Slot geometry of a 6-slot frame and the signed per-frame bias encoding.
package pipa_pkg;

  localparam int SLOTS_PER_FRAME = 6;
  localparam int BASE_PLUS       = 3;
  localparam int SLOT_RESET      = 5;

  localparam logic [2:0] SLOT_LAST  = 3'(SLOTS_PER_FRAME - 1);
  localparam logic [2:0] SLOT_RST_V = 3'(SLOT_RESET);

  typedef logic signed [1:0] bias_t;

  localparam bias_t BIAS_NEG  = -2'sd1;
  localparam bias_t BIAS_ZERO = 2'sd0;
  localparam bias_t BIAS_POS  = 2'sd1;

endpackage

// File: rtl/pipa_axis_mod.sv
// One PIPA axis: rate accumulator, per-frame bias and registered p/m drive.
// Ports: CLOCK/rst_n, slot_i, boundary_i, dat_i, enable_i, rate_i, dir_i -> p_o, m_o.
module pipa_axis_mod
  import pipa_pkg::*;
#(
  parameter int RATE_W = 8
) (
  input  logic              CLOCK,
  input  logic              rst_n,
  input  logic [2:0]        slot_i,
  input  logic              boundary_i,
  input  logic              dat_i,
  input  logic              enable_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              dir_i,
  output logic              p_o,
  output logic              m_o
);

  logic [RATE_W-1:0] acc_q, acc_d;
  bias_t             bias_q, bias_d;
  logic              p_q, p_d;
  logic              m_q, m_d;
  logic [RATE_W:0]   sum;
  logic signed [3:0] lim;
  logic signed [3:0] slot_s;
  logic              plus_sel;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, rate_i};
    acc_d  = acc_q;
    bias_d = bias_q;
    if (boundary_i) begin
      acc_d  = sum[RATE_W-1:0];
      bias_d = sum[RATE_W] ? (dir_i ? BIAS_NEG : BIAS_POS)
                           : BIAS_ZERO;
    end
  end

  // Plus window is slots [0, 3+bias); bias moves one slot across.
  always_comb begin
    lim      = 4'sd3 + $signed({{2{bias_q[1]}}, bias_q});
    slot_s   = $signed({1'b0, slot_i});
    plus_sel = (slot_s < lim);
    p_d      = enable_i & dat_i & plus_sel;
    m_d      = enable_i & dat_i & ~plus_sel;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= BIAS_ZERO;
      p_q    <= 1'b0;
      m_q    <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      p_q    <= p_d;
      m_q    <= m_d;
    end
  end

  assign p_o = p_q;
  assign m_o = m_q;

endmodule

// File: rtl/pipa_moding_ctrl.sv
// PIPA moding scheduler: syncs PIPASW/PIPDAT, runs the 6-slot frame and timeout.
// Ports: CLOCK/rst_n, enable, pipasw, pipdat, rate_*/dir_* -> pipa_*, slot, frame_strobe, sw_timeout.
module pipa_moding_ctrl
  import pipa_pkg::*;
#(
  parameter int RATE_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLOCK,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pipasw,
  input  logic              pipdat,
  input  logic [RATE_W-1:0] rate_x,
  input  logic [RATE_W-1:0] rate_y,
  input  logic [RATE_W-1:0] rate_z,
  input  logic              dir_x,
  input  logic              dir_y,
  input  logic              dir_z,
  output logic              pipa_xp,
  output logic              pipa_xm,
  output logic              pipa_yp,
  output logic              pipa_ym,
  output logic              pipa_zp,
  output logic              pipa_zm,
  output logic [2:0]        slot,
  output logic              frame_strobe,
  output logic              sw_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic          sw_meta_q, sw_s_q, sw_dly_q;
  logic          dat_meta_q, dat_s_q;
  logic [2:0]    slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          fs_q, fs_d;
  logic          sw_edge;
  logic          boundary;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= 1'b0;
      sw_s_q     <= 1'b0;
      sw_dly_q   <= 1'b0;
      dat_meta_q <= 1'b0;
      dat_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= pipasw;
      sw_s_q     <= sw_meta_q;
      sw_dly_q   <= sw_s_q;
      dat_meta_q <= pipdat;
      dat_s_q    <= dat_meta_q;
    end
  end

  always_comb begin
    sw_edge  = sw_s_q & ~sw_dly_q;
    boundary = enable & sw_edge & (slot_q == SLOT_LAST);
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    fs_d     = boundary;
    if (!enable) begin
      cnt_d = '0;
    end else if (sw_edge) begin
      slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
      cnt_d  = '0;
      tmo_d  = 1'b0;
    end else if (cnt_q != TMO_MAX) begin
      cnt_d = cnt_q + 1'b1;
      // Stale PIPASW: park on the last slot so the next edge starts a frame.
      if (cnt_q == TMO_LAST) begin
        slot_d = SLOT_RST_V;
        tmo_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_RST_V;
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
      fs_q   <= fs_d;
    end
  end

  pipa_axis_mod #(.RATE_W(RATE_W)) u_x (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .slot_i     (slot_q),
    .boundary_i (boundary),
    .dat_i      (dat_s_q),
    .enable_i   (enable),
    .rate_i     (rate_x),
    .dir_i      (dir_x),
    .p_o        (pipa_xp),
    .m_o        (pipa_xm)
  );

  pipa_axis_mod #(.RATE_W(RATE_W)) u_y (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .slot_i     (slot_q),
    .boundary_i (boundary),
    .dat_i      (dat_s_q),
    .enable_i   (enable),
    .rate_i     (rate_y),
    .dir_i      (dir_y),
    .p_o        (pipa_yp),
    .m_o        (pipa_ym)
  );

  pipa_axis_mod #(.RATE_W(RATE_W)) u_z (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .slot_i     (slot_q),
    .boundary_i (boundary),
    .dat_i      (dat_s_q),
    .enable_i   (enable),
    .rate_i     (rate_z),
    .dir_i      (dir_z),
    .p_o        (pipa_zp),
    .m_o        (pipa_zm)
  );

  assign slot         = slot_q;
  assign frame_strobe = fs_q;
  assign sw_timeout   = tmo_q;

endmodule

// File: tb/tb_pipa_moding_ctrl.sv
// Directed bench for pipa_moding_ctrl.
// Steps PIPASW/PIPDAT by hand and checks slots, strobes and p/m patterns.
module tb_pipa_moding_ctrl;

  logic       CLOCK = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       pipasw;
  logic       pipdat;
  logic [7:0] rate_x, rate_y, rate_z;
  logic       dir_x, dir_y, dir_z;
  logic       pipa_xp, pipa_xm;
  logic       pipa_yp, pipa_ym;
  logic       pipa_zp, pipa_zm;
  logic [2:0] slot;
  logic       frame_strobe;
  logic       sw_timeout;

  int compared   = 0;
  int mismatched = 0;
  int overlap    = 0;

  logic [5:0] outs;
  assign outs = {pipa_xp, pipa_xm, pipa_yp, pipa_ym, pipa_zp, pipa_zm};

  always #5 CLOCK = ~CLOCK;

  pipa_moding_ctrl #(.RATE_W(8), .TIMEOUT(4096)) dut (
    .CLOCK        (CLOCK),
    .rst_n        (rst_n),
    .enable       (enable),
    .pipasw       (pipasw),
    .pipdat       (pipdat),
    .rate_x       (rate_x),
    .rate_y       (rate_y),
    .rate_z       (rate_z),
    .dir_x        (dir_x),
    .dir_y        (dir_y),
    .dir_z        (dir_z),
    .pipa_xp      (pipa_xp),
    .pipa_xm      (pipa_xm),
    .pipa_yp      (pipa_yp),
    .pipa_ym      (pipa_ym),
    .pipa_zp      (pipa_zp),
    .pipa_zm      (pipa_zm),
    .slot         (slot),
    .frame_strobe (frame_strobe),
    .sw_timeout   (sw_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ax(input int s, input int b);
    return (s < 3 + b) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [5:0] pat(input int s, input int bx,
                                     input int by, input int bz);
    return {ax(s, bx), ax(s, by), ax(s, bz)};
  endfunction

  task automatic sample(inout logic fs, inout logic [5:0] seen);
    fs   = fs | frame_strobe;
    seen = seen | outs;
    if ((pipa_xp & pipa_xm) | (pipa_yp & pipa_ym) | (pipa_zp & pipa_zm))
      overlap++;
  endtask

  task automatic sw_pulse(input logic with_dat, output logic fs,
                          output logic [5:0] seen);
    fs   = 1'b0;
    seen = '0;
    @(negedge CLOCK);
    pipasw = 1'b1;
    pipdat = with_dat;
    @(negedge CLOCK);
    pipdat = 1'b0;
    sample(fs, seen);
    @(negedge CLOCK);
    pipasw = 1'b0;
    sample(fs, seen);
    repeat (4) begin
      @(negedge CLOCK);
      sample(fs, seen);
    end
  endtask

  task automatic dat_pulse(output logic [5:0] seen);
    logic fs;
    fs   = 1'b0;
    seen = '0;
    @(negedge CLOCK);
    pipdat = 1'b1;
    @(negedge CLOCK);
    pipdat = 1'b0;
    sample(fs, seen);
    repeat (4) begin
      @(negedge CLOCK);
      sample(fs, seen);
    end
  endtask

  task automatic step(output logic fs, output logic [5:0] seen);
    logic [5:0] dummy;
    sw_pulse(1'b0, fs, dummy);
    dat_pulse(seen);
  endtask

  initial begin
    logic       fs;
    logic [5:0] seen;
    int         xp, xm, yp_f, ym_t, biased;

    rst_n  = 1'b0;
    enable = 1'b1;
    pipasw = 1'b0;
    pipdat = 1'b0;
    rate_x = '0; rate_y = '0; rate_z = '0;
    dir_x  = 1'b0; dir_y = 1'b0; dir_z = 1'b0;

    repeat (3) @(negedge CLOCK);
    chk("rst_slot", 32'(slot), 32'd5);
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_fs", 32'(frame_strobe), 32'd0);
    chk("rst_tmo", 32'(sw_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge CLOCK);
    chk("rel_slot", 32'(slot), 32'd5);

    // Pure 3-3 moding, two frames
    for (int k = 0; k < 12; k++) begin
      step(fs, seen);
      chk("t1_slot", 32'(slot), 32'(k % 6));
      chk("t1_fs", 32'(fs), 32'(k % 6 == 0));
      chk("t1_out", 32'(seen), 32'(pat(k % 6, 0, 0, 0)));
    end

    // X at half rate, positive
    rate_x = 8'd128;
    xp = 0; xm = 0;
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 6; s++) begin
        step(fs, seen);
        chk("t2_slot", 32'(slot), 32'(s));
        chk("t2_out", 32'(seen), 32'(pat(s, f % 2, 0, 0)));
        xp += int'(seen[5]);
        xm += int'(seen[4]);
      end
    end
    chk("t2_xplus", 32'(xp), 32'd14);
    chk("t2_xminus", 32'(xm), 32'd10);
    rate_x = '0;

    // Y at full rate, negative: every frame but the first is biased
    rate_y = 8'd255;
    dir_y  = 1'b1;
    biased = 0;
    ym_t   = 0;
    for (int f = 0; f < 256; f++) begin
      yp_f = 0;
      for (int s = 0; s < 6; s++) begin
        step(fs, seen);
        yp_f += int'(seen[3]);
        ym_t += int'(seen[2]);
      end
      if (yp_f == 2) biased++;
    end
    chk("t3_biased", 32'(biased), 32'd255);
    chk("t3_yminus", 32'(ym_t), 32'd1023);
    rate_y = '0;
    dir_y  = 1'b0;

    // PIPASW stall from slot 3
    repeat (4) step(fs, seen);
    chk("t4_slot3", 32'(slot), 32'd3);
    repeat (4000) @(negedge CLOCK);
    chk("t4_tmo_early", 32'(sw_timeout), 32'd0);
    chk("t4_slot_early", 32'(slot), 32'd3);
    repeat (200) @(negedge CLOCK);
    chk("t4_tmo", 32'(sw_timeout), 32'd1);
    chk("t4_slot5", 32'(slot), 32'd5);
    step(fs, seen);
    chk("t4_resync_slot", 32'(slot), 32'd0);
    chk("t4_resync_fs", 32'(fs), 32'd1);
    chk("t4_resync_tmo", 32'(sw_timeout), 32'd0);
    chk("t4_out", 32'(seen), 32'(pat(0, 0, 0, 0)));

    // Disable at slot 2 with edges present
    repeat (2) step(fs, seen);
    chk("t5_slot2", 32'(slot), 32'd2);
    @(negedge CLOCK);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sw_pulse(1'b1, fs, seen);
      chk("t5_dis_out", 32'(seen), 32'd0);
      dat_pulse(seen);
      chk("t5_dis_dat", 32'(seen), 32'd0);
    end
    repeat (35) @(negedge CLOCK);
    chk("t5_hold_slot", 32'(slot), 32'd2);
    enable = 1'b1;
    step(fs, seen);
    chk("t5_resume_slot", 32'(slot), 32'd3);
    chk("t5_resume_out", 32'(seen), 32'(pat(3, 0, 0, 0)));

    // Edge and data in the same synchronized cycle at slot 2
    repeat (5) step(fs, seen);
    chk("t6_slot2", 32'(slot), 32'd2);
    sw_pulse(1'b1, fs, seen);
    chk("t6_same_out", 32'(seen), 32'(pat(2, 0, 0, 0)));
    chk("t6_same_slot", 32'(slot), 32'd3);
    dat_pulse(seen);
    chk("t6_next_out", 32'(seen), 32'(pat(3, 0, 0, 0)));

    // Reset mid-frame with PIPDAT held high
    @(negedge CLOCK);
    pipdat = 1'b1;
    repeat (4) @(negedge CLOCK);
    chk("t7_pre_outs", 32'(outs), 32'(pat(3, 0, 0, 0)));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_slot", 32'(slot), 32'd5);
    chk("t7_rst_outs", 32'(outs), 32'd0);
    @(negedge CLOCK);
    chk("t7_rst_hold", 32'(outs), 32'd0);
    pipdat = 1'b0;
    rst_n  = 1'b1;
    @(negedge CLOCK);

    chk("overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
